// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, PC+4 adder and the IF/ID
// pipeline register, with stall, flush and halt-opcode control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] next_pc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  // Modulo-2^32 add; the carry out is deliberately dropped.
  assign pc_plus4 = pc_q + 32'd4;

  // Priority below is flush, then stall, then normal fetch; rst is applied
  // in the register process and overrides all of it.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the
    // if/else chain can leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    count_d = count_q;

    if (flush) begin
      instr_d = 32'd0;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
      if (state_q == ST_RUN) pc_d = next_pc;
    end else if (stall) begin
      // Everything holds.
    end else if (state_q == ST_RUN) begin
      instr_d = imem_rdata;
      pp4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
      if (imem_rdata[31:26] == HALT_OP) state_d = ST_HALT;
      else                              pc_d    = next_pc;
    end else begin
      // Halted: keep feeding bubbles downstream, PC frozen.
      instr_d = 32'd0;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pp4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == ST_HALT);
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/flush/reset traffic, all compared against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        tie;
  logic [31:0] np_val;
  logic [31:0] next_pc, imem_rdata;
  logic [31:0] pc, pc_plus4, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  logic        w_rst;
  logic [31:0] w_pc, w_pc_plus4, w_instr, w_pp4, w_count;
  logic        w_valid, w_halted;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_halt;

  always #5 clk = ~clk;

  assign next_pc    = tie ? pc_plus4 : np_val;
  assign imem_rdata = mem[pc[7:2]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .next_pc(next_pc), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst), .stall(1'b0), .flush(1'b0),
    .next_pc(w_pc_plus4), .imem_rdata(32'h0000_0000),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .if_id_instr(w_instr),
    .if_id_pc_plus4(w_pp4), .if_id_valid(w_valid),
    .halted(w_halted), .fetch_count(w_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, computed from the rules of the stage.
  task automatic model_edge();
    logic [31:0] word, np;
    word = mem[m_pc[7:2]];
    np   = tie ? m_pc + 32'd4 : np_val;
    if (rst) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0;
      m_valid = 1'b0; m_cnt = 32'd0; m_halt = 1'b0;
    end else if (flush) begin
      m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
      if (!m_halt) m_pc = np;
    end else if (stall) begin
      // hold
    end else if (!m_halt) begin
      m_instr = word; m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      if (word[31:26] == 6'h3F) m_halt = 1'b1;
      else                      m_pc = np;
    end else begin
      m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       pc,             m_pc);
    check({tag, ".pc4"},      pc_plus4,       m_pc + 32'd4);
    check({tag, ".instr"},    if_id_instr,    m_instr);
    check({tag, ".id_pc4"},   if_id_pc_plus4, m_pp4);
    check({tag, ".valid"},    {31'd0, if_id_valid}, {31'd0, m_valid});
    check({tag, ".halted"},   {31'd0, halted},      {31'd0, m_halt});
    check({tag, ".count"},    fetch_count,    m_cnt);
  endtask

  // One cycle: drive inputs away from the edge, advance the model, sample #1
  // after the rising edge.
  task automatic cyc(input string tag, input logic r, input logic s, input logic f,
                     input logic t, input logic [31:0] npv);
    rst = r; stall = s; flush = f; tie = t; np_val = npv;
    #1;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] word;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; tie = 1'b1; np_val = 32'd0; w_rst = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + i;

    // Reset and sequential fetch
    cyc("rst0", 1, 0, 0, 1, 0);
    cyc("rst1", 1, 0, 0, 1, 0);
    check("rst_pc", pc, 32'h0);
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc_plus4, 32'h0);
    w_rst = 1'b0;
    cyc("seq0", 0, 0, 0, 1, 0);
    check("wrap_pc_after", w_pc, 32'h0);
    check("wrap_pc4_after", w_pc_plus4, 32'h4);
    check("seq0_pc", pc, 32'h4);
    check("seq0_instr", if_id_instr, 32'h2000_0000);
    cyc("seq1", 0, 0, 0, 1, 0);
    check("seq1_pc", pc, 32'h8);

    // Stall at pc = 8
    cyc("stall0", 0, 1, 0, 1, 0);
    cyc("stall1", 0, 1, 0, 1, 0);
    check("stall_pc", pc, 32'h8);
    check("stall_id_pc4", if_id_pc_plus4, 32'h8);
    check("stall_count", fetch_count, 32'd2);
    cyc("seq2", 0, 0, 0, 1, 0);
    check("seq2_pc", pc, 32'hC);
    check("seq2_instr", if_id_instr, 32'h2000_0002);
    check("seq2_count", fetch_count, 32'd3);

    // Flush overriding stall
    cyc("flush", 0, 1, 1, 0, 32'h40);
    check("flush_pc", pc, 32'h40);
    check("flush_valid", {31'd0, if_id_valid}, 32'd0);
    check("flush_instr", if_id_instr, 32'h0);

    // Halt at 0x10
    mem[4] = 32'hFC00_0000;
    cyc("hrst", 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("hseq", 0, 0, 0, 1, 0);
    check("hseq_pc", pc, 32'h10);
    cyc("hcap", 0, 0, 0, 1, 0);
    check("halt_instr", if_id_instr, 32'hFC00_0000);
    check("halt_valid", {31'd0, if_id_valid}, 32'd1);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 0, 0, 0, 1, 0);
      check("halt_bubble", {31'd0, if_id_valid}, 32'd0);
      check("halt_pc_hold", pc, 32'h10);
    end
    cyc("hexit", 1, 0, 0, 1, 0);
    check("hexit_pc", pc, 32'h0);
    check("hexit_halted", {31'd0, halted}, 32'd0);

    // Reset together with stall and flush
    cyc("pre0", 0, 0, 0, 1, 0);
    cyc("pre1", 0, 0, 0, 1, 0);
    cyc("mid_rst", 1, 1, 1, 0, 32'h80);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_count", fetch_count, 32'd0);
    check("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);

    // Random traffic
    for (int i = 0; i < 64; i++) begin
      word = $urandom;
      if ($urandom_range(0, 15) == 0) word[31:26] = 6'h3F;
      else if (word[31:26] == 6'h3F)  word[31:26] = 6'h00;
      mem[i] = word;
    end
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 0),
          32'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
